mix_columns_seq: RTL and testbench

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

---
 rtl/mix_columns_seq.sv | 126 ++++++++++++
 tb/tb_mix_columns_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: one column per cycle, in place, with a final-round bypass.
// Optional InvMixColumns selected by in_inv when MIX_COLUMNS_INV_EN is defined.
module mix_columns_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_bus,
  input  logic         in_last,
`ifdef MIX_COLUMNS_INV_EN
  input  logic         in_inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_reg, state_next;
  logic [1:0]   col_reg, col_next;
  logic [127:0] data_reg, data_next;
  logic [31:0]  col_word;
  logic [31:0]  mixed;
  logic [7:0]   c0, c1, c2, c3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Shift-and-add multiply; with constant-ish coefficients this folds to a few XORs.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] k);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  logic inv_reg, inv_next;

  always_comb begin
    if (inv_reg) begin
      c0 = 8'h0E; c1 = 8'h0B; c2 = 8'h0D; c3 = 8'h09;
    end else begin
      c0 = 8'h02; c1 = 8'h03; c2 = 8'h01; c3 = 8'h01;
    end
  end
`else
  assign c0 = 8'h02;
  assign c1 = 8'h03;
  assign c2 = 8'h01;
  assign c3 = 8'h01;
`endif

  assign col_word = data_reg[{col_reg, 5'b0} +: 32];

  // Row r uses the coefficient vector rotated by r bytes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign mixed[8*gi +: 8] = gf_mul(col_word[8*gi +: 8], c0)
                              ^ gf_mul(col_word[8*((gi+1)%4) +: 8], c1)
                              ^ gf_mul(col_word[8*((gi+2)%4) +: 8], c2)
                              ^ gf_mul(col_word[8*((gi+3)%4) +: 8], c3);
    end
  endgenerate

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_bus   = data_reg;

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    data_next  = data_reg;
`ifdef MIX_COLUMNS_INV_EN
    inv_next   = inv_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          data_next  = in_bus;
          col_next   = 2'd0;
`ifdef MIX_COLUMNS_INV_EN
          inv_next   = in_inv;
`endif
          state_next = in_last ? DONE : BUSY;
        end
      end
      BUSY: begin
        data_next[{col_reg, 5'b0} +: 32] = mixed;
        col_next = col_reg + 2'd1;
        if (col_reg == 2'd3) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      col_reg   <= 2'd0;
      data_reg  <= '0;
`ifdef MIX_COLUMNS_INV_EN
      inv_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      data_reg  <= data_next;
`ifdef MIX_COLUMNS_INV_EN
      inv_reg   <= inv_next;
`endif
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq: driver pushes expected results, a negedge monitor pops and checks.
// Exercises the inverse path too when MIX_COLUMNS_INV_EN is defined.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_bus = '0;
  logic         in_last = 1'b0;
  logic         in_inv = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_bus;

  int n_vec = 0;
  int n_miss = 0;
  int cycle = 0;

  typedef struct {
    logic [127:0] data;
    int           lat;
    int           acc;
  } exp_t;
  exp_t q[$];

  mix_columns_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_bus(in_bus), .in_last(in_last),
`ifdef MIX_COLUMNS_INV_EN
    .in_inv(in_inv),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_bus(out_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  // Monitor: latency on first valid cycle, stability while stalled, data on handshake.
  logic         seen = 1'b0;
  logic         post = 1'b0;
  logic [127:0] held = '0;
  always @(negedge clk) begin
    if (post) begin
      post = 1'b0;
      check("ready_after_pop", {126'd0, in_ready, out_valid}, 128'd2);
    end
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_output", out_bus, 128'hx);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          held = out_bus;
          check("latency", 128'(cycle - q[0].acc + 1), 128'(q[0].lat));
        end else begin
          check("stall_stable", out_bus, held);
          check("stall_in_ready", {127'd0, in_ready}, 128'd0);
        end
        if (out_ready) begin
          check("data", out_bus, q[0].data);
          void'(q.pop_front());
          seen = 1'b0;
          post = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic last, input logic inv,
                      input logic [127:0] e, input int lat);
    exp_t x;
    @(negedge clk);
    in_valid = 1'b1;
    in_bus   = d;
    in_last  = last;
    in_inv   = inv;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    check("accept_wait", {127'd0, in_ready}, 128'd1);
    if (in_ready) begin
      x.data = e;
      x.lat  = lat;
      x.acc  = cycle + 1;
      q.push_back(x);
    end
    @(negedge clk);
    // Scramble inputs after accept; the DUT must ignore them.
    in_valid = 1'b0;
    in_bus   = ~d;
    in_last  = ~last;
    in_inv   = ~inv;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    check("drain", 128'(q.size()), 128'd0);
  endtask

  localparam logic [127:0] V1 = {32'h01010101, 32'h4C31262D, 32'hD5D4D4D4, 32'h455313DB};
  localparam logic [127:0] E1 = {32'h01010101, 32'hF8BD7E4D, 32'hD6D7D5D5, 32'hBCA14D8E};
  localparam logic [127:0] V_ONES = {4{32'h01010101}};
  localparam logic [127:0] V_C6   = {4{32'hC6C6C6C6}};
  localparam logic [127:0] V_BYP  = 128'h00112233445566778899AABBCCDDEEFF;

  initial begin
    #1;
    check("reset_out_valid", {127'd0, out_valid}, 128'd0);
    check("reset_out_bus", out_bus, 128'd0);
    check("reset_in_ready", {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back known-answer vectors.
    send(V1, 1'b0, 1'b0, E1, 5);
    send(V_ONES, 1'b0, 1'b0, V_ONES, 5);
    send(V_C6, 1'b0, 1'b0, V_C6, 5);
    send(V_BYP, 1'b1, 1'b0, V_BYP, 1);
    send(V1, 1'b1, 1'b0, V1, 1);
    drain();

`ifdef MIX_COLUMNS_INV_EN
    send(E1, 1'b0, 1'b1, V1, 5);
    send(E1, 1'b1, 1'b1, E1, 1);
    drain();
`endif

    // Backpressure: hold out_ready low for 10 cycles in DONE.
    out_ready = 1'b0;
    send(V1, 1'b0, 1'b0, E1, 5);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("bp_valid_seen", {127'd0, out_valid}, 128'd1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Reset while col=2: partial result must vanish and never emerge.
    @(negedge clk);
    in_valid = 1'b1;
    in_bus   = V1;
    in_last  = 1'b0;
    in_inv   = 1'b0;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_bus", out_bus, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_idle", {126'd0, in_ready, out_valid}, 128'd2);

    // Still functional after the mid-flight reset.
    send(V_C6, 1'b0, 1'b0, V_C6, 5);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
